regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-port register file; next generation of the 3-read/1-write ARM register file.
// - Sits between decode (read addresses) and execute/writeback (two write ports).
// - Adds N read ports, 2 write ports with fixed priority, async reset and a self-incrementing PC (R15).
// - Collision flag for same-address writes.
// PARAMETERS
// DATA_W       32   register width in bits
// NUM_REGS     16   register count; AW = $clog2(NUM_REGS); must be >= 2
// NUM_RD       3    number of read ports
// PC_IDX       15   index of the program-counter register
// PC_INC       4    PC increment per PC_LE cycle
// PC_READ_OFS  8    value added to the PC when it is read through a PA port (ARM pipeline view)
// PORTS
// CLK       in   1               clock, rising edge
// RST_N     in   1               asynchronous reset, active low
// E0        in   1               write enable, port 0 (ALU result)
// RW0       in   AW              write address, port 0
// PW0       in   DATA_W          write data, port 0
// E1        in   1               write enable, port 1 (load / base writeback)
// RW1       in   AW              write address, port 1
// PW1       in   DATA_W          write data, port 1
// PC_LE     in   1               PC auto-increment enable
// RA        in   NUM_RD*AW       packed read addresses; port k uses bits [k*AW +: AW]
// PA        out  NUM_RD*DATA_W   packed read data; port k uses bits [k*DATA_W +: DATA_W]
// PC_OUT    out  DATA_W          raw PC value (register PC_IDX, no offset) for instruction fetch
// COLLIDE   out  1               registered; 1 for one cycle after a same-address dual write
// BEHAVIOUR
// - Reset (RST_N low, async): all registers = 0, COLLIDE = 0, PC_OUT = 0, immediately.
// - Writes on the rising edge of CLK only.
// - Write port 0: E0=1 -> reg[RW0] <= PW0. Write port 1: E1=1 -> reg[RW1] <= PW1.
// - E0 & E1 & RW0==RW1: port 0 wins; port 1 is dropped; COLLIDE = 1 on the next cycle, else 0.
// - PC update priority at each edge:
//   - a port write to PC_IDX (port 0 over port 1),
//   - else PC_LE=1 -> PC <= PC + PC_INC (modulo 2^DATA_W, wraps silently),
//   - else hold.
// - Reads are combinational, zero latency: PA[k] = reg[RA[k]].
// - RA[k]==PC_IDX -> PA[k] = PC + PC_READ_OFS (modulo 2^DATA_W).
// - RA[k] >= NUM_REGS (non-power-of-2 depth) -> PA[k] = 0. A write to such an address is ignored.
// - All read ports are independent; identical addresses on several ports give identical data.
// - Reset during active write: reset wins; no partial update survives.
// - No state machine beyond the PC counter and the COLLIDE register.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: read ports forward same-cycle write data.
//   - RA[k] matches an enabled write address -> PA[k] = winning PW, after priority resolution.
//   - For PC_IDX the forwarded value is PW + PC_READ_OFS.
//   - PC_LE increments are not forwarded.
// - Undefined: reads show only the register contents (new data visible the cycle after the write).
// STRUCTURE
// - Package regfile_pkg: defaults for DATA_W, NUM_REGS, PC_IDX, PC_INC and PC_READ_OFS; function clog2;
//   typedef for write-port struct {we, addr, data}.
// - Sub-module regfile_pc_ctr: PC register with write/increment/hold priority, async reset; outputs raw PC.
// - Top: general register array (excludes PC_IDX), write decode, collision register, NUM_RD read muxes
//   generated by a for-generate loop.
// TESTING
// - Reset: after RST_N low, every RA and PC_OUT read back 0; PC read via PA returns 32'h8.
// - Single write: E0=1, RW0=5, PW0=AABBCCDD, one edge; RA[0]=5 -> PA[0]=AABBCCDD.
//   Without bypass, same-cycle read = 0.
// - Dual write, different addresses: RW0=3/11223344, RW1=10/55667788 on one edge; both read back.
//   COLLIDE stays 0.
// - Collision: E0=E1=1, RW0=RW1=7, PW0=1, PW1=2; reg7 = 1, COLLIDE = 1 for exactly one cycle.
// - PC: PC_LE=1 for 3 edges -> PC_OUT=C, PA(RA=15)=14.
//   Then E1 writes 100 to R15 with PC_LE=1 -> PC_OUT=100.
//   Preload FFFFFFFC and increment -> wraps to 0.
// - Bypass (REGFILE_BYPASS_EN): E0=1, RW0=4, PW0=DEADBEEF, RA[2]=4 -> PA[2]=DEADBEEF before the edge.
//   Mid-write async reset -> all zero.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and write-port bundle
// for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int NUM_REGS_DEF    = 16;
   localparam int PC_IDX_DEF      = 15;
   localparam int PC_INC_DEF      = 4;
   localparam int PC_READ_OFS_DEF = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   localparam int AW_DEF = clog2(NUM_REGS_DEF);

   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wport_t;

endpackage

// File: rtl/regfile_pc_ctr.sv
// Program-counter register: port write beats auto-increment,
// auto-increment beats hold; wraps silently.
module regfile_pc_ctr
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_INC = PC_INC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              le,
   output logic [DATA_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (we) begin
         pc <= wdata;
      end else if (le) begin
         pc <= pc + DATA_W'(PC_INC);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, 2 prioritised write
// ports, self-incrementing PC. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int NUM_RD      = 3,
   parameter int PC_IDX      = PC_IDX_DEF,
   parameter int PC_INC      = PC_INC_DEF,
   parameter int PC_READ_OFS = PC_READ_OFS_DEF,
   parameter int AW          = clog2(NUM_REGS)
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     E0,
   input  logic [AW-1:0]            RW0,
   input  logic [DATA_W-1:0]        PW0,
   input  logic                     E1,
   input  logic [AW-1:0]            RW1,
   input  logic [DATA_W-1:0]        PW1,
   input  logic                     PC_LE,
   input  logic [NUM_RD*AW-1:0]     RA,
   output logic [NUM_RD*DATA_W-1:0] PA,
   output logic [DATA_W-1:0]        PC_OUT,
   output logic                     COLLIDE
);

   localparam logic [DATA_W-1:0] OFS = DATA_W'(PC_READ_OFS);

   logic [NUM_REGS*DATA_W-1:0] rv;
   logic [NUM_REGS*DATA_W-1:0] rview;
   logic                       collide_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic              we0;
      logic              we1;
      logic              we;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] v;

      // port 0 wins a same-address dual write
      assign we0 = E0 && (RW0 == AW'(i));
      assign we1 = E1 && (RW1 == AW'(i)) && !we0;
      assign we  = we0 || we1;
      assign wd  = we0 ? PW0 : PW1;

      if (i == PC_IDX) begin : g_pc
         regfile_pc_ctr #(
            .DATA_W (DATA_W),
            .PC_INC (PC_INC)
         ) u_pc (
            .clk   (CLK),
            .rst_n (RST_N),
            .we    (we),
            .wdata (wd),
            .le    (PC_LE),
            .pc    (q)
         );
      end else begin : g_gpr
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               q <= '0;
            end else if (we) begin
               q <= wd;
            end
         end
      end

`ifdef REGFILE_BYPASS_EN
      assign v = we ? wd : q;
`else
      assign v = q;
`endif

      assign rv[i*DATA_W +: DATA_W]    = q;
      assign rview[i*DATA_W +: DATA_W] = (i == PC_IDX) ? v + OFS : v;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd;

      assign ra = RA[k*AW +: AW];

      // unmatched (out-of-range) addresses read as zero
      always_comb begin
         rd = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ra == AW'(i)) rd = rview[i*DATA_W +: DATA_W];
         end
      end

      assign PA[k*DATA_W +: DATA_W] = rd;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         collide_q <= 1'b0;
      end else begin
         collide_q <= E0 && E1 && (RW0 == RW1);
      end
   end

   assign PC_OUT  = rv[PC_IDX*DATA_W +: DATA_W];
   assign COLLIDE = collide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp (default geometry:
// 32-bit, 16 regs, 3 read ports, PC at R15).
module tb_regfile_mp;

   logic        CLK;
   logic        RST_N;
   logic        E0;
   logic [3:0]  RW0;
   logic [31:0] PW0;
   logic        E1;
   logic [3:0]  RW1;
   logic [31:0] PW1;
   logic        PC_LE;
   logic [11:0] RA;
   logic [95:0] PA;
   logic [31:0] PC_OUT;
   logic        COLLIDE;

   int checks;
   int failures;

   regfile_mp dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .E0      (E0),
      .RW0     (RW0),
      .PW0     (PW0),
      .E1      (E1),
      .RW1     (RW1),
      .PW1     (PW1),
      .PC_LE   (PC_LE),
      .RA      (RA),
      .PA      (PA),
      .PC_OUT  (PC_OUT),
      .COLLIDE (COLLIDE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        e0;
      logic [3:0]  rw0;
      logic [31:0] pw0;
      logic        e1;
      logic [3:0]  rw1;
      logic [31:0] pw1;
      logic        le;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [31:0] x0;
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] xpc;
      logic        xc;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle();
      E0 = 1'b0; RW0 = '0; PW0 = '0;
      E1 = 1'b0; RW1 = '0; PW1 = '0;
      PC_LE = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      idle();
      RA = '0;
      RST_N = 1'b0;

      //        e0  rw0  pw0           e1  rw1  pw1          le  ra0 ra1 ra2  x0            x1            x2            xpc           xc
      vt[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  15, 32'h0,        32'h0,        32'h8,        32'h0,        0};
      vt[1]  = '{1, 5,  32'hAABBCCDD, 0, 0,  32'h0,        0, 5,  0,  15, 32'hAABBCCDD, 32'h0,        32'h8,        32'h0,        0};
      vt[2]  = '{1, 3,  32'h11223344, 1, 10, 32'h55667788, 0, 3,  10, 5,  32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'h0,        0};
      vt[3]  = '{1, 7,  32'h1,        1, 7,  32'h2,        0, 7,  7,  3,  32'h1,        32'h1,        32'h11223344, 32'h0,        1};
      vt[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 7,  0,  0,  32'h1,        32'h0,        32'h0,        32'h0,        0};
      vt[5]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 15, 15, 15, 32'hC,        32'hC,        32'hC,        32'h4,        0};
      vt[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 15, 15, 15, 32'h10,       32'h10,       32'h10,       32'h8,        0};
      vt[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 15, 15, 15, 32'h14,       32'h14,       32'h14,       32'hC,        0};
      vt[8]  = '{0, 0,  32'h0,        1, 15, 32'h100,      1, 15, 0,  0,  32'h108,      32'h0,        32'h0,        32'h100,      0};
      vt[9]  = '{1, 15, 32'h200,      1, 15, 32'h300,      1, 15, 7,  5,  32'h208,      32'h1,        32'hAABBCCDD, 32'h200,      1};
      vt[10] = '{1, 15, 32'hFFFFFFFC, 0, 0,  32'h0,        0, 15, 0,  0,  32'h4,        32'h0,        32'h0,        32'hFFFFFFFC, 0};
      vt[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 15, 0,  0,  32'h8,        32'h0,        32'h0,        32'h0,        0};
      vt[12] = '{1, 1,  32'h11,       1, 15, 32'h40,       1, 1,  15, 2,  32'h11,       32'h48,       32'h0,        32'h40,       0};
      vt[13] = '{0, 0,  32'h0,        1, 7,  32'h77,       0, 7,  7,  7,  32'h77,       32'h77,       32'h77,       32'h40,       0};
      vt[14] = '{1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,        0, 0,  3,  10, 32'hFFFFFFFF, 32'h11223344, 32'h55667788, 32'h40,       0};

      // reset state: every general register reads 0, PC reads as 0+8
      #3;
      for (int r = 0; r < 15; r++) begin
         RA = {4'd15, 4'(r), 4'(r)};
         #1;
         chk($sformatf("rst_r%0d", r), PA[31:0], 32'h0);
      end
      chk("rst_pa_pc", PA[95:64], 32'h8);
      chk("rst_pc_out", PC_OUT, 32'h0);
      chk("rst_collide", {31'h0, COLLIDE}, 32'h0);

      @(negedge CLK);
      RST_N = 1'b1;

      for (int v = 0; v < 15; v++) begin
         @(negedge CLK);
         E0 = vt[v].e0; RW0 = vt[v].rw0; PW0 = vt[v].pw0;
         E1 = vt[v].e1; RW1 = vt[v].rw1; PW1 = vt[v].pw1;
         PC_LE = vt[v].le;
         RA = {vt[v].ra2, vt[v].ra1, vt[v].ra0};
         @(posedge CLK);
         #1;
         idle();
         #1;
         chk($sformatf("v%0d_pa0", v), PA[31:0], vt[v].x0);
         chk($sformatf("v%0d_pa1", v), PA[63:32], vt[v].x1);
         chk($sformatf("v%0d_pa2", v), PA[95:64], vt[v].x2);
         chk($sformatf("v%0d_pc", v), PC_OUT, vt[v].xpc);
         chk($sformatf("v%0d_col", v), {31'h0, COLLIDE}, {31'h0, vt[v].xc});
      end

      // same-cycle read of a pending write to R4
      @(negedge CLK);
      E0 = 1'b1; RW0 = 4'd4; PW0 = 32'hDEADBEEF;
      RA = {4'd4, 4'd15, 4'd0};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same_cycle", PA[95:64], 32'hDEADBEEF);
`else
      chk("nobyp_same_cycle", PA[95:64], 32'h0);
`endif
      @(posedge CLK);
      #1;
      idle();
      #1;
      chk("r4_after_edge", PA[95:64], 32'hDEADBEEF);

      // async reset in the middle of an active dual write
      @(negedge CLK);
      E0 = 1'b1; RW0 = 4'd6; PW0 = 32'h66;
      E1 = 1'b1; RW1 = 4'd6; PW1 = 32'h99;
      PC_LE = 1'b1;
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_pc_now", PC_OUT, 32'h0);
      @(posedge CLK);
      #1;
      idle();
      #1;
      RA = {4'd6, 4'd4, 4'd0};
      #1;
      chk("mid_rst_r0", PA[31:0], 32'h0);
      chk("mid_rst_r4", PA[63:32], 32'h0);
      chk("mid_rst_r6", PA[95:64], 32'h0);
      chk("mid_rst_pc", PC_OUT, 32'h0);
      chk("mid_rst_col", {31'h0, COLLIDE}, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      RA = {4'd15, 4'd7, 4'd6};
      #1;
      chk("post_rst_r6", PA[31:0], 32'h0);
      chk("post_rst_r7", PA[63:32], 32'h0);
      chk("post_rst_pa_pc", PA[95:64], 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
